// File: rtl/collatz_pkg.sv
// Shared definitions for the Collatz stream monitor: FSM state encoding and
// default widths/limits used by the top level and the next-term helper.
package collatz_pkg;

   localparam int DATAWIDTH_DEF = 8;
   localparam int MAX_STEPS_DEF = 255;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_TRACK,
      ST_DONE,
      ST_ERROR
   } state_t;

endpackage

// File: rtl/collatz_next_term.sv
// Combinational Collatz step f(n): n>>1 for even n, 3n+1 for odd n, with an
// overflow flag when 3n+1 does not fit back into DATAWIDTH bits.
module collatz_next_term
   import collatz_pkg::*;
#(
   parameter int DATAWIDTH = DATAWIDTH_DEF
) (
   input  logic [DATAWIDTH-1:0] n,
   output logic [DATAWIDTH-1:0] next,
   output logic                 ovf
);

   localparam logic [DATAWIDTH+1:0] ONE_WIDE = 1;

   // Two guard bits hold 3n+1 exactly for any DATAWIDTH-bit n.
   logic [DATAWIDTH+1:0] triple_plus_one;

   assign triple_plus_one = {2'b00, n} + {1'b0, n, 1'b0} + ONE_WIDE;
   assign next            = n[0] ? triple_plus_one[DATAWIDTH-1:0] : (n >> 1);
   assign ovf             = n[0] & (|triple_plus_one[DATAWIDTH+1:DATAWIDTH]);

endmodule

// File: rtl/collatz_stream_monitor.sv
// Receive-side Collatz checker: recomputes each expected term from the seed and
// flags mismatch/overflow/timeout. Peak tracking is built only with COLLATZ_MON_PEAK_EN.
module collatz_stream_monitor
   import collatz_pkg::*;
#(
   parameter int DATAWIDTH = DATAWIDTH_DEF,
   parameter int MAX_STEPS = MAX_STEPS_DEF
) (
   input  logic                 BB_SYSTEM_CLOCK_50,
   input  logic                 BB_SYSTEM_RESET_InHigh,
   input  logic                 mon_start,
   input  logic [DATAWIDTH-1:0] mon_seed,
   input  logic                 mon_valid,
   input  logic [DATAWIDTH-1:0] mon_data_InBUS,
   output logic                 mon_busy,
   output logic                 mon_done,
   output logic                 mon_error,
   output logic                 mon_overflow,
   output logic [DATAWIDTH-1:0] mon_steps,
   output logic [DATAWIDTH-1:0] mon_peak
);

   localparam logic [DATAWIDTH-1:0] ONE       = 1;
   localparam logic [DATAWIDTH-1:0] STEP_HALT = DATAWIDTH'(MAX_STEPS);

   state_t               state;
   logic [DATAWIDTH-1:0] expected;
   logic [DATAWIDTH-1:0] steps;
   logic                 busy_q, done_q, error_q, ovf_q;

   logic [DATAWIDTH-1:0] seed_next, sample_next, steps_inc;
   logic                 seed_ovf, sample_ovf, term_match;

   collatz_next_term #(.DATAWIDTH(DATAWIDTH)) u_seed_term (
      .n    (mon_seed),
      .next (seed_next),
      .ovf  (seed_ovf)
   );

   collatz_next_term #(.DATAWIDTH(DATAWIDTH)) u_sample_term (
      .n    (mon_data_InBUS),
      .next (sample_next),
      .ovf  (sample_ovf)
   );

   assign steps_inc  = steps + 1'b1;
   // Start has priority, so a sample coinciding with it never counts as a match.
   assign term_match = (state == ST_TRACK) && mon_valid && !mon_start
                       && (mon_data_InBUS == expected);

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge BB_SYSTEM_CLOCK_50 or posedge BB_SYSTEM_RESET_InHigh) begin
      if (BB_SYSTEM_RESET_InHigh) begin
         state    <= ST_IDLE;
         expected <= '0;
         steps    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else if (mon_start) begin
         steps    <= '0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         expected <= seed_next;
         if (mon_seed == '0) begin
            state   <= ST_ERROR;
            error_q <= 1'b1;
         end else if (mon_seed == ONE) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
         end else if (seed_ovf) begin
            state   <= ST_ERROR;
            error_q <= 1'b1;
            ovf_q   <= 1'b1;
         end else begin
            state  <= ST_TRACK;
            busy_q <= 1'b1;
         end
      end else if (state == ST_TRACK && mon_valid) begin
         if (!term_match) begin
            state   <= ST_ERROR;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
         end else begin
            steps <= steps_inc;
            if (mon_data_InBUS == ONE) begin
               state  <= ST_DONE;
               done_q <= 1'b1;
               busy_q <= 1'b0;
            end else if (steps_inc == STEP_HALT) begin
               state   <= ST_ERROR;
               error_q <= 1'b1;
               busy_q  <= 1'b0;
            end else if (sample_ovf) begin
               state   <= ST_ERROR;
               error_q <= 1'b1;
               ovf_q   <= 1'b1;
               busy_q  <= 1'b0;
            end else begin
               expected <= sample_next;
            end
         end
      end
   end

   assign mon_busy     = busy_q;
   assign mon_done     = done_q;
   assign mon_error    = error_q;
   assign mon_overflow = ovf_q;
   assign mon_steps    = steps;

`ifdef COLLATZ_MON_PEAK_EN
   logic [DATAWIDTH-1:0] peak;

   always_ff @(posedge BB_SYSTEM_CLOCK_50 or posedge BB_SYSTEM_RESET_InHigh) begin
      if (BB_SYSTEM_RESET_InHigh) begin
         peak <= '0;
      end else if (mon_start) begin
         peak <= mon_seed;
      end else if (term_match && (mon_data_InBUS > peak)) begin
         peak <= mon_data_InBUS;
      end
   end

   assign mon_peak = peak;
`else
   assign mon_peak = '0;
`endif

endmodule
